// File: rtl/uart_link_ctrl_pkg.sv
// Shared definitions for the UART link controller: TX sequencer state
// encodings, arbitration grant encodings, the transmitter busy timeout and
// the round-robin grant selection.
package uart_link_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_ECHO = 1'b1
  } grant_t;

  // Cycles spent in WAIT_BUSY before the byte is assumed sent.
  localparam int BUSY_TIMEOUT = 4;
  localparam int TIMEOUT_W    = 2;

  // Round-robin choice: on a tie the requester not granted last wins.
  function automatic grant_t pick_grant(input logic cpu_req,
                                        input logic echo_req,
                                        input grant_t last);
    if (cpu_req && echo_req) return (last == GNT_ECHO) ? GNT_CPU : GNT_ECHO;
    else if (cpu_req)        return GNT_CPU;
    else                     return GNT_ECHO;
  endfunction

endpackage

// File: rtl/uart_link_ctrl_rx_fifo.sv
// uart_rx_fifo: circular receive buffer between the UART receiver and the CPU.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, push_data   store a received byte
//   pop               remove the head byte (ignored when empty)
//   clr_overrun       clears the sticky overrun flag (wins over a set)
//   head              head byte, 0 when empty
//   count             occupancy 0..FIFO_DEPTH
//   overrun           sticky flag: a byte was dropped while full
module uart_rx_fifo
  import uart_link_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  input  logic             clr_overrun,
  output logic [7:0]       head,
  output logic [PTR_W:0]   count,
  output logic             overrun
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign do_push = push && (!full || do_pop);

  assign head = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      if (clr_overrun)            overrun <= 1'b0;
      else if (push && !do_push)  overrun <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: receive buffering, optional echo and round-robin sharing of
// the UART transmitter between the CPU and the echo path. Clocked by the 16x
// baud clock BRclk.
// Ports:
//   BRclk, reset               clock, asynchronous active-low reset
//   rx_status, rx_data         byte strobe and byte from the receiver
//   echo_en                    queue received bytes for echo
//   cpu_rd                     pop the RX FIFO head
//   rx_head, rx_count          FIFO head byte (0 when empty) and occupancy
//   rx_overrun, clr_overrun    sticky drop flag and its clear
//   cpu_tx_req, cpu_tx_data    CPU transmit request and byte
//   cpu_tx_ack                 pulse when the CPU byte is launched
//   tx_en, tx_data             launch pulse and byte to the transmitter
//   tx_busy                    transmitter busy level
module uart_link_ctrl
  import uart_link_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic             BRclk,
  input  logic             reset,
  input  logic             rx_status,
  input  logic [7:0]       rx_data,
  input  logic             echo_en,
  input  logic             cpu_rd,
  output logic [7:0]       rx_head,
  output logic [PTR_W:0]   rx_count,
  output logic             rx_overrun,
  input  logic             clr_overrun,
  input  logic             cpu_tx_req,
  input  logic [7:0]       cpu_tx_data,
  output logic             cpu_tx_ack,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  input  logic             tx_busy
);

  tx_state_t            state;
  grant_t               last_grant;
  grant_t               sel;
  logic                 echo_valid;
  logic [7:0]           echo_byte;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 echo_clear;
  logic                 echo_load;

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_rx_fifo (
    .clk         (BRclk),
    .reset       (reset),
    .push        (rx_status),
    .push_data   (rx_data),
    .pop         (cpu_rd),
    .clr_overrun (clr_overrun),
    .head        (rx_head),
    .count       (rx_count),
    .overrun     (rx_overrun)
  );

  // The echo slot empties on an echo launch; a byte arriving in that very
  // cycle takes the slot instead of being dropped.
  assign echo_clear = (state == LAUNCH) && (sel == GNT_ECHO);
  assign echo_load  = rx_status && echo_en && (!echo_valid || echo_clear);

  always_ff @(posedge BRclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GNT_ECHO;
      sel        <= GNT_CPU;
      echo_valid <= 1'b0;
      echo_byte  <= 8'h00;
      wait_cnt   <= '0;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      cpu_tx_ack <= 1'b0;
    end else begin
      tx_en      <= 1'b0;
      cpu_tx_ack <= 1'b0;

      if (echo_load) begin
        echo_valid <= 1'b1;
        echo_byte  <= rx_data;
      end else if (echo_clear) begin
        echo_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cpu_tx_req || echo_valid) begin
            sel   <= pick_grant(cpu_tx_req, echo_valid, last_grant);
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en      <= 1'b1;
          tx_data    <= (sel == GNT_CPU) ? cpu_tx_data : echo_byte;
          cpu_tx_ack <= (sel == GNT_CPU);
          last_grant <= sel;
          wait_cnt   <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never reports busy is treated as done.
          if (tx_busy)
            state <= WAIT_DONE;
          else if (wait_cnt == TIMEOUT_W'(BUSY_TIMEOUT - 1))
            state <= IDLE;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
module tb_uart_link_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          BRclk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_status = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          echo_en = 1'b0;
  logic          cpu_rd = 1'b0;
  logic [7:0]    rx_head;
  logic [PW:0]   rx_count;
  logic          rx_overrun;
  logic          clr_overrun = 1'b0;
  logic          cpu_tx_req = 1'b0;
  logic [7:0]    cpu_tx_data = 8'h00;
  logic          cpu_tx_ack;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_link_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
    .BRclk       (BRclk),
    .reset       (reset),
    .rx_status   (rx_status),
    .rx_data     (rx_data),
    .echo_en     (echo_en),
    .cpu_rd      (cpu_rd),
    .rx_head     (rx_head),
    .rx_count    (rx_count),
    .rx_overrun  (rx_overrun),
    .clr_overrun (clr_overrun),
    .cpu_tx_req  (cpu_tx_req),
    .cpu_tx_data (cpu_tx_data),
    .cpu_tx_ack  (cpu_tx_ack),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy)
  );

  always #5 BRclk = ~BRclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge BRclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b; rx_status = 1'b1;
    tick();
    rx_status = 1'b0;
  endtask

  task automatic pop();
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic wait_launch(input int budget, output bit seen,
                             output logic [7:0] d, output logic ack);
    seen = 1'b0; d = 8'h00; ack = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_en === 1'b1) begin
        seen = 1'b1; d = tx_data; ack = cpu_tx_ack;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge BRclk);
    #1;
    n_checks++;
    if ({tx_en, cpu_tx_ack, rx_overrun, tx_data, rx_head, rx_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: tx_en=%b ack=%b ovr=%b tx_data=%h head=%h count=%0d, need all 0",
               tx_en, cpu_tx_ack, rx_overrun, tx_data, rx_head, rx_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fifo_basic();
    push(8'hA5);
    push(8'h3C);
    n_checks++;
    if (rx_count !== 3'd2 || rx_head !== 8'hA5) begin
      n_fail++; $display("FAIL fifo_two: count=%0d head=%h, need 2/a5", rx_count, rx_head);
    end
    pop();
    n_checks++;
    if (rx_count !== 3'd1 || rx_head !== 8'h3C) begin
      n_fail++; $display("FAIL fifo_pop1: count=%0d head=%h, need 1/3c", rx_count, rx_head);
    end
    pop();
    n_checks++;
    if (rx_count !== 3'd0 || rx_head !== 8'h00) begin
      n_fail++; $display("FAIL fifo_empty: count=%0d head=%h, need 0/00", rx_count, rx_head);
    end
    pop();
    n_checks++;
    if (rx_count !== 3'd0 || rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL fifo_pop_empty: count=%0d ovr=%b, need 0/0", rx_count, rx_overrun);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) push(8'(i));
    n_checks++;
    if (rx_count !== 3'd4 || rx_overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: count=%0d ovr=%b, need 4/1", rx_count, rx_overrun);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (rx_head !== 8'(i)) begin
        n_fail++; $display("FAIL overrun_pop%0d: head=%h, need %h", i, rx_head, 8'(i));
      end
      pop();
    end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    n_checks++;
    if (rx_overrun !== 1'b0 || rx_count !== 3'd0) begin
      n_fail++; $display("FAIL overrun_clear: ovr=%b count=%0d, need 0/0", rx_overrun, rx_count);
    end
    // Clear wins over a drop in the same cycle.
    for (int i = 0; i < 4; i++) push(8'hE0);
    rx_data = 8'hEE; rx_status = 1'b1; clr_overrun = 1'b1;
    tick();
    rx_status = 1'b0; clr_overrun = 1'b0;
    n_checks++;
    if (rx_overrun !== 1'b0 || rx_count !== 3'd4) begin
      n_fail++; $display("FAIL overrun_clr_priority: ovr=%b count=%0d, need 0/4", rx_overrun, rx_count);
    end
    repeat (4) pop();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    rx_data = 8'h77; rx_status = 1'b1; cpu_rd = 1'b1;
    tick();
    rx_status = 1'b0; cpu_rd = 1'b0;
    n_checks++;
    if (rx_count !== 3'd4 || rx_overrun !== 1'b0 || rx_head !== 8'h11) begin
      n_fail++; $display("FAIL full_push_pop: count=%0d ovr=%b head=%h, need 4/0/11",
                         rx_count, rx_overrun, rx_head);
    end
    repeat (3) pop();
    n_checks++;
    if (rx_head !== 8'h77 || rx_count !== 3'd1) begin
      n_fail++; $display("FAIL full_push_pop_last: head=%h count=%0d, need 77/1", rx_head, rx_count);
    end
    pop();
  endtask

  task automatic test_fifo_random();
    logic [7:0] q[$];
    bit ov;
    ov = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit rs, rd, cl, drop;
      logic [7:0] b, exp_head;
      int exp_cnt;
      rs = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 15) == 0);
      b  = 8'($urandom);
      rx_status = rs; rx_data = b; cpu_rd = rd; clr_overrun = cl;
      drop = 1'b0;
      if (rd && q.size() > 0) void'(q.pop_front());
      if (rs) begin
        if (q.size() < DEPTH) q.push_back(b);
        else drop = 1'b1;
      end
      if (cl) ov = 1'b0;
      else if (drop) ov = 1'b1;
      tick();
      exp_cnt  = q.size();
      exp_head = (q.size() > 0) ? q[0] : 8'h00;
      n_checks++;
      if (rx_count !== 3'(exp_cnt) || rx_head !== exp_head || rx_overrun !== ov) begin
        n_fail++;
        $display("FAIL fifo_random cycle %0d: count=%0d head=%h ovr=%b, need %0d/%h/%b",
                 c, rx_count, rx_head, rx_overrun, exp_cnt, exp_head, ov);
      end
    end
    rx_status = 1'b0; cpu_rd = 1'b0; clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    repeat (DEPTH) pop();
  endtask

  task automatic test_latency_ack();
    cpu_tx_req = 1'b1; cpu_tx_data = 8'hC3;
    tick();
    n_checks++;
    if (tx_en !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: tx_en=%b, need 0", tx_en);
    end
    tick();
    n_checks++;
    if (tx_en !== 1'b1 || tx_data !== 8'hC3 || cpu_tx_ack !== 1'b1) begin
      n_fail++; $display("FAIL latency_launch: tx_en=%b data=%h ack=%b, need 1/c3/1",
                         tx_en, tx_data, cpu_tx_ack);
    end
    cpu_tx_req = 1'b0; tx_busy = 1'b1;
    tick();
    n_checks++;
    if (tx_en !== 1'b0 || cpu_tx_ack !== 1'b0 || tx_data !== 8'hC3) begin
      n_fail++; $display("FAIL latency_pulse: tx_en=%b ack=%b data=%h, need 0/0/c3",
                         tx_en, cpu_tx_ack, tx_data);
    end
    tick();
    tx_busy = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    bit seen; logic [7:0] d; logic ack; int k;
    cpu_tx_req = 1'b1; cpu_tx_data = 8'hE1;
    wait_launch(4, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'hE1 || ack !== 1'b1) begin
      n_fail++; $display("FAIL timeout_first: seen=%0d data=%h ack=%b, need 1/e1/1", seen, d, ack);
    end
    cpu_tx_data = 8'h5A;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (tx_en === 1'b1) begin k = i; break; end
    end
    n_checks++;
    if (k != 6 || tx_data !== 8'h5A || cpu_tx_ack !== 1'b1) begin
      n_fail++; $display("FAIL timeout_relaunch: cycles=%0d data=%h ack=%b, need 6/5a/1",
                         k, tx_data, cpu_tx_ack);
    end
    cpu_tx_req = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_arbitration();
    bit seen; logic [7:0] d; logic ack;
    echo_en = 1'b1; rx_data = 8'h55; rx_status = 1'b1;
    cpu_tx_req = 1'b1; cpu_tx_data = 8'hAA;
    tick();
    rx_status = 1'b0; echo_en = 1'b0;
    wait_launch(4, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'hAA || ack !== 1'b1) begin
      n_fail++; $display("FAIL arb_cpu_first: seen=%0d data=%h ack=%b, need 1/aa/1", seen, d, ack);
    end
    cpu_tx_req = 1'b0; tx_busy = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (tx_en !== 1'b0) begin
      n_fail++; $display("FAIL arb_hold_while_busy: tx_en=%b, need 0", tx_en);
    end
    tx_busy = 1'b0;
    wait_launch(6, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h55 || ack !== 1'b0) begin
      n_fail++; $display("FAIL arb_echo_second: seen=%0d data=%h ack=%b, need 1/55/0", seen, d, ack);
    end
    tx_busy = 1'b1; tick(); tx_busy = 1'b0; tick(); tick();
    n_checks++;
    if (rx_count !== 3'd1 || rx_head !== 8'h55) begin
      n_fail++; $display("FAIL arb_fifo_copy: count=%0d head=%h, need 1/55", rx_count, rx_head);
    end
    pop();
  endtask

  task automatic test_round_robin();
    bit seen; logic [7:0] d; logic ack; int extra;
    cpu_tx_req = 1'b1; cpu_tx_data = 8'h11;
    wait_launch(4, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h11 || ack !== 1'b1) begin
      n_fail++; $display("FAIL rr_cpu_11: seen=%0d data=%h ack=%b, need 1/11/1", seen, d, ack);
    end
    cpu_tx_req = 1'b0; tx_busy = 1'b1;
    tick();
    echo_en = 1'b1;
    push(8'h66);
    cpu_tx_req = 1'b1; cpu_tx_data = 8'h99;
    tick(); tick();
    tx_busy = 1'b0;
    wait_launch(6, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h66 || ack !== 1'b0) begin
      n_fail++; $display("FAIL rr_tie_echo: seen=%0d data=%h ack=%b, need 1/66/0", seen, d, ack);
    end
    // Echo slot frees at the launch: 0x21 is taken, 0x22 is dropped.
    tx_busy = 1'b1;
    push(8'h21);
    push(8'h22);
    echo_en = 1'b0;
    tx_busy = 1'b0;
    wait_launch(6, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h99 || ack !== 1'b1) begin
      n_fail++; $display("FAIL rr_tie_cpu: seen=%0d data=%h ack=%b, need 1/99/1", seen, d, ack);
    end
    cpu_tx_req = 1'b0;
    tx_busy = 1'b1; tick(); tx_busy = 1'b0;
    wait_launch(6, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h21 || ack !== 1'b0) begin
      n_fail++; $display("FAIL echo_keep_first: seen=%0d data=%h ack=%b, need 1/21/0", seen, d, ack);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_en === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++; $display("FAIL echo_drop_second: extra launches=%0d, need 0", extra);
    end
    n_checks++;
    if (rx_count !== 3'd3 || rx_head !== 8'h66) begin
      n_fail++; $display("FAIL echo_fifo_all: count=%0d head=%h, need 3/66", rx_count, rx_head);
    end
    pop(); pop();
    n_checks++;
    if (rx_head !== 8'h22) begin
      n_fail++; $display("FAIL echo_fifo_third: head=%h, need 22", rx_head);
    end
    pop();
  endtask

  task automatic test_echo_reload();
    bit seen; logic [7:0] d; logic ack;
    echo_en = 1'b1;
    push(8'h31);
    tick();
    push(8'h32);
    echo_en = 1'b0;
    n_checks++;
    if (tx_en !== 1'b1 || tx_data !== 8'h31 || cpu_tx_ack !== 1'b0) begin
      n_fail++; $display("FAIL reload_first: tx_en=%b data=%h ack=%b, need 1/31/0",
                         tx_en, tx_data, cpu_tx_ack);
    end
    wait_launch(10, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h32 || ack !== 1'b0) begin
      n_fail++; $display("FAIL reload_second: seen=%0d data=%h ack=%b, need 1/32/0", seen, d, ack);
    end
    repeat (8) tick();
    n_checks++;
    if (rx_head !== 8'h31 || rx_count !== 3'd2) begin
      n_fail++; $display("FAIL reload_fifo: head=%h count=%0d, need 31/2", rx_head, rx_count);
    end
    pop(); pop();
  endtask

  task automatic test_first_tie();
    bit seen; logic [7:0] d; logic ack;
    reset = 1'b0; #2; reset = 1'b1;
    tick();
    echo_en = 1'b1;
    push(8'h44);
    echo_en = 1'b0;
    cpu_tx_req = 1'b1; cpu_tx_data = 8'h88;
    tick();
    n_checks++;
    if (tx_en !== 1'b0) begin
      n_fail++; $display("FAIL first_tie_early: tx_en=%b, need 0", tx_en);
    end
    tick();
    n_checks++;
    if (tx_en !== 1'b1 || tx_data !== 8'h88 || cpu_tx_ack !== 1'b1) begin
      n_fail++; $display("FAIL first_tie_cpu: tx_en=%b data=%h ack=%b, need 1/88/1",
                         tx_en, tx_data, cpu_tx_ack);
    end
    cpu_tx_req = 1'b0;
    wait_launch(12, seen, d, ack);
    n_checks++;
    if (!seen || d !== 8'h44 || ack !== 1'b0) begin
      n_fail++; $display("FAIL first_tie_echo: seen=%0d data=%h ack=%b, need 1/44/0", seen, d, ack);
    end
    repeat (8) tick();
    pop();
  endtask

  task automatic test_reset_mid();
    bit seen; logic [7:0] d; logic ack; int extra;
    cpu_tx_req = 1'b1; cpu_tx_data = 8'h7E;
    wait_launch(4, seen, d, ack);
    cpu_tx_req = 1'b0; tx_busy = 1'b1;
    tick();
    echo_en = 1'b1;
    push(8'h12);
    echo_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx_en !== 1'b0 || cpu_tx_ack !== 1'b0 || rx_count !== 3'd0 ||
        rx_head !== 8'h00 || tx_data !== 8'h00 || rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: tx_en=%b ack=%b count=%0d head=%h data=%h ovr=%b, need all 0",
                         tx_en, cpu_tx_ack, rx_count, rx_head, tx_data, rx_overrun);
    end
    tx_busy = 1'b0;
    #3;
    reset = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_en === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0 || rx_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_lost: launches=%0d count=%0d, need 0/0", extra, rx_count);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_overrun();
    test_full_push_pop();
    test_fifo_random();
    test_latency_ack();
    test_timeout();
    test_arbitration();
    test_round_robin();
    test_echo_reload();
    test_first_tie();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_link_ctrl.md
# uart_link_ctrl

Sequencing and arbitration controller for the UART peripheral, clocked by the 16x baud clock BRclk. It captures bytes from the UART receiver into a small RX FIFO for the CPU, and optionally queues them for echo. It also shares the single UART transmitter between the CPU transmit path and the echo path using round-robin arbitration. It sits between the receiver/transmitter pair and the peripheral register interface.

## Interface
Parameters:
- FIFO_DEPTH, 4, RX FIFO entries; power of two, ≥2
- PTR_W, 2, log2(FIFO_DEPTH)

Ports:
- BRclk  in  1  16x baud clock; all logic on posedge
- reset  in  1  asynchronous, active-low
- rx_status  in  1  one-cycle pulse from receiver: new byte valid
- rx_data  in  8  received byte, valid with rx_status
- echo_en  in  1  level; when 1, each received byte is also queued for echo
- cpu_rd  in  1  one-cycle pop request of RX FIFO head
- rx_head  out  8  FIFO head byte; 0 when empty
- rx_count  out  PTR_W+1  FIFO occupancy
- rx_overrun  out  1  sticky; set when a byte is dropped at full
- clr_overrun  in  1  clears rx_overrun
- cpu_tx_req  in  1  level; CPU has a byte to send
- cpu_tx_data  in  8  byte, stable while cpu_tx_req=1
- cpu_tx_ack  out  1  one-cycle pulse when the CPU byte is launched
- tx_en  out  1  one-cycle launch pulse to transmitter
- tx_data  out  8  byte to transmit; held from launch until the transaction returns to IDLE
- tx_busy  in  1  transmitter busy level

## Operation
- RX FIFO: circular buffer with rd_ptr and wr_ptr (PTR_W bits, wrap modulo FIFO_DEPTH) and a count register.
  - Push on rx_status. Pop on cpu_rd when count>0.
  - cpu_rd while empty: ignored.
- Simultaneous push+pop:
  - Not full: both occur; count unchanged.
  - Full: pop frees the slot, push is accepted, no overrun.
- Push at full without pop: byte dropped, rx_overrun←1.
  - clr_overrun has priority over a simultaneous set.
- Echo holding register: echo_valid/echo_byte.
  - On rx_status with echo_en=1 and echo_valid=0: load the byte.
  - If echo_valid=1: the new echo is dropped silently; the FIFO still receives the byte.
- TX FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE:
    - If cpu_tx_req or echo_valid, select a requester → LAUNCH.
    - Tie between both: the requester not granted last wins.
    - last_grant resets to ECHO, so the CPU wins the first tie.
  - LAUNCH (1 cycle):
    - tx_en=1, tx_data=selected byte, update last_grant.
    - CPU grant: cpu_tx_ack=1 in the same cycle. Echo grant: clear echo_valid.
    - → WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1 → WAIT_DONE.
    - After 4 cycles without tx_busy, return to IDLE; the byte is treated as sent.
  - WAIT_DONE: wait for tx_busy=0 → IDLE.
- A new rx_status arriving while echo_valid is being cleared in LAUNCH loads the echo register in that same cycle.

## Timing
- Reset values: every output 0, state IDLE, pointers/count 0, echo_valid 0, last_grant ECHO, rx_overrun 0.
- Reset mid-transfer: abort immediately. Any FIFO contents and pending echo are lost.
- rx_head is registered-pointer-indexed and combinational from the FIFO array:
  - Valid the cycle after a push into an empty FIFO.
  - Advances the cycle after a pop.
- rx_count updates on the clock edge following push/pop.
- Request to launch latency: 1 cycle. Request sampled in IDLE at edge N gives tx_en high for the cycle after edge N+1.
- Minimum IDLE-to-IDLE cycle: 4 cycles (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
- The CPU must deassert cpu_tx_req or change data only after cpu_tx_ack; a held request sends again.

## Structure
- Shared package constants:
  - TX state encodings: IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
  - Grant encodings: GNT_CPU=1'b0, GNT_ECHO=1'b1.
  - BUSY_TIMEOUT=4.
- One sub-module: uart_rx_fifo (FIFO_DEPTH/PTR_W parameters; push, pop, data, count, overrun logic). The arbiter/FSM lives in the top.

## Test plan
- Receive 0xA5, 0x3C, then cpu_rd twice → rx_head 0xA5 then 0x3C; rx_count 2→1→0; rx_head 0 when empty.
- Push 5 bytes 0x01..0x05 into a depth-4 FIFO → rx_count=4, rx_overrun=1, pops yield 0x01..0x04. clr_overrun → 0.
- Full FIFO with push 0x77 and cpu_rd in the same cycle → no overrun, count stays 4, 0x77 is popped last.
- echo_en=1, rx 0x55, and cpu_tx_req with 0xAA asserted simultaneously → first launch 0xAA with cpu_tx_ack, then 0x55 after tx_busy falls.
- Launch with tx_busy held 0 → after 4 WAIT_BUSY cycles the FSM returns to IDLE and the next request launches.
- Assert reset during WAIT_DONE → tx_en=0, state IDLE, rx_count=0, echo_valid=0 immediately, without waiting for a clock edge.
